// File: rtl/cache_fill_fsm_if.sv
// Cache fill controller bus bundle.
// Miss request in, memory request/response, cache array writes out.
interface cache_fill_fsm_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);

  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic [DATA_WIDTH-1:0] memory_data;
  logic                  memory_data_valid;
  logic                  fsm_busy;
  logic                  memory_read_en;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic                  write_data_array;
  logic                  write_tag_array;
  logic [ADDR_WIDTH-1:0] cache_write_address;
  logic [DATA_WIDTH-1:0] cache_write_data;

  // cache + memory side
  modport master (
    output miss_detected,
    output miss_address,
    output memory_data,
    output memory_data_valid,
    input  fsm_busy,
    input  memory_read_en,
    input  memory_address,
    input  write_data_array,
    input  write_tag_array,
    input  cache_write_address,
    input  cache_write_data
  );

  // fill controller side
  modport slave (
    input  miss_detected,
    input  miss_address,
    input  memory_data,
    input  memory_data_valid,
    output fsm_busy,
    output memory_read_en,
    output memory_address,
    output write_data_array,
    output write_tag_array,
    output cache_write_address,
    output cache_write_data
  );

endinterface

// File: rtl/cache_fill_fsm.sv
// L1 miss fill controller: fetches one block word by word from
// memory and streams it into the cache, tag written on last word.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 16
) (
  input  logic            clk,
  input  logic            rst,
  cache_fill_fsm_if.slave bus
);

  localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W  = OFF_W + 1;
  localparam int BASE_W = ADDR_WIDTH - OFF_W - 1;

  localparam logic [CNT_W-1:0] REQ_END =
    CNT_W'(WORDS_PER_BLOCK);
  localparam logic [OFF_W-1:0] RSP_LAST =
    OFF_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t            r_state;
  logic [BASE_W-1:0] r_base;
  logic [CNT_W-1:0]  r_req_cnt;
  logic [OFF_W-1:0]  r_rsp_cnt;

  logic                  w_fill;
  logic                  w_req;
  logic                  w_rsp;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [OFF_W:0]        w_unused_addr;

  assign w_fill = (r_state == S_FILL);
  assign w_req  = w_fill && (r_req_cnt < REQ_END);
  assign w_rsp  = w_fill && bus.memory_data_valid;
  assign w_last = w_rsp && (r_rsp_cnt == RSP_LAST);

  // byte offset within the block never matters
  assign w_unused_addr = bus.miss_address[OFF_W:0];
  assign w_wr_data     = bus.memory_data;

  assign bus.fsm_busy         = w_fill;
  assign bus.memory_read_en   = w_req;
  assign bus.write_data_array = w_rsp;
  assign bus.write_tag_array  = w_last;
  assign bus.cache_write_data = w_wr_data;

  // concatenation keeps every address inside the block
  assign bus.memory_address =
    {r_base, r_req_cnt[OFF_W-1:0], 1'b0};
  assign bus.cache_write_address =
    {r_base, r_rsp_cnt, 1'b0};

  // fill sequencer: latch block on miss, count requests/responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.miss_detected) begin
            r_base    <=
              bus.miss_address[ADDR_WIDTH-1:OFF_W+1];
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
            r_state   <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_req)
            r_req_cnt <= r_req_cnt + CNT_W'(1);
          if (w_rsp)
            r_rsp_cnt <= r_rsp_cnt + OFF_W'(1);
          if (w_last)
            r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-cycle
// memory model and optional gaps between responses.
module tb_cache_fill_fsm;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cache_fill_fsm_if bus ();

  cache_fill_fsm u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill(
    input logic [15:0] addr,
    input bit          gaps,
    input bit          hold,
    input bit          poke
  );
    logic [15:0] base;
    logic [15:0] md;
    int          q[$];
    int          nreq;
    int          nrsp;
    int          nbusy;
    int          nxt;
    bit          done;
    base  = {addr[15:4], 4'h0};
    nreq  = 0;
    nrsp  = 0;
    nbusy = 0;
    nxt   = 0;
    done  = 1'b0;
    chk("idle_busy", bus.fsm_busy, 0);
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    step();
    if (!hold) bus.miss_detected = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      if (poke && c == 3) begin
        bus.miss_detected = 1'b1;
        bus.miss_address  = 16'h4000;
      end
      if (poke && c == 4) begin
        bus.miss_detected = 1'b0;
        bus.miss_address  = addr;
      end
      nbusy += int'(bus.fsm_busy);
      chk("rd_en", bus.memory_read_en, c <= 8);
      if (bus.memory_read_en) begin
        chk("rd_addr", bus.memory_address,
            base + 2 * nreq);
        q.push_back(c);
        nreq++;
      end
      if (q.size() > 0 && c >= q[0] + 4 && c >= nxt)
      begin
        void'(q.pop_front());
        md = base ^ (16'h1111 * 16'(nrsp + 1));
        bus.memory_data       = md;
        bus.memory_data_valid = 1'b1;
        #1;
        chk("wr_data_en", bus.write_data_array, 1);
        chk("wr_addr", bus.cache_write_address,
            base + 2 * nrsp);
        chk("wr_data", bus.cache_write_data, md);
        chk("wr_tag", bus.write_tag_array, nrsp == 7);
        if (nrsp == 7) done = 1'b1;
        nrsp++;
        nxt = c + 1;
        if (gaps) nxt += $urandom_range(0, 3);
      end else begin
        bus.memory_data       = 16'hDEAD;
        bus.memory_data_valid = 1'b0;
        #1;
        chk("no_wr", bus.write_data_array, 0);
        chk("no_tag", bus.write_tag_array, 0);
      end
      step();
      bus.memory_data_valid = 1'b0;
    end
    if (!done) chk("fill_timeout", 0, 1);
    chk("nreq", nreq, 8);
    if (!gaps) chk("busy_cycles", nbusy, 12);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.miss_detected     = 1'b0;
    bus.miss_address      = 16'h0;
    bus.memory_data       = 16'h0;
    bus.memory_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.fsm_busy, 0);
    chk("rst_rd", bus.memory_read_en, 0);
    chk("rst_wd", bus.write_data_array, 0);
    chk("rst_wt", bus.write_tag_array, 0);
    chk("rst_maddr", bus.memory_address, 0);
    chk("rst_caddr", bus.cache_write_address, 0);
    rst = 1'b0;
    step();

    // reset in the middle of a fill after 3 responses
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h1236;
    step();
    bus.miss_detected = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      bus.memory_data_valid = (c >= 5);
      #1;
      chk("mid_busy", bus.fsm_busy, 1);
      step();
    end
    bus.memory_data_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_busy", bus.fsm_busy, 0);
    chk("mrst_rd", bus.memory_read_en, 0);
    chk("mrst_wd", bus.write_data_array, 0);
    chk("mrst_wt", bus.write_tag_array, 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.memory_data_valid = c[0];
      #1;
      chk("post_busy", bus.fsm_busy, 0);
      chk("post_rd", bus.memory_read_en, 0);
      chk("post_wd", bus.write_data_array, 0);
      chk("post_maddr", bus.memory_address, 0);
      step();
    end
    bus.memory_data_valid = 1'b0;

    // stray response while idle
    bus.memory_data_valid = 1'b1;
    #1;
    chk("idle_wd", bus.write_data_array, 0);
    chk("idle_wt", bus.write_tag_array, 0);
    step();
    bus.memory_data_valid = 1'b0;

    run_fill(16'h1236, 1'b0, 1'b0, 1'b0);
    run_fill(16'h5678, 1'b1, 1'b0, 1'b0);
    run_fill(16'h1230, 1'b0, 1'b0, 1'b1);
    run_fill(16'hFFFA, 1'b0, 1'b1, 1'b0);
    run_fill(16'hFFF2, 1'b1, 1'b0, 1'b0);
    chk("final_busy", bus.fsm_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
